// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine feeding the HI/LO register.
// One radix-2 step per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  input  logic [2*WIDTH-1:0] hilo_cur,
  input  logic               flush,
  output logic               busy,
  output logic               hilo_we,
  output logic [2*WIDTH-1:0] hilo_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic               is_arith;
  logic               is_signed_op;
  logic               is_div_op;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;

  logic               is_signed;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;

  logic               neg_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] result;

  always_comb begin
    is_arith     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    is_div_op    = (op == OP_DIV) || (op == OP_DIVU);
    rs_mag       = (is_signed_op && rs[WIDTH-1]) ? -rs : rs;
    rt_mag       = (is_signed_op && rt[WIDTH-1]) ? -rt : rt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Flush overrides every transition, including FIX back to IDLE with a write.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && is_arith) next_state = CALC;
      CALC:    if (cnt == CNT_W'(1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) begin
      next_state = IDLE;
    end
  end

  // Multiplier sits in the low half of acc and is consumed LSB-first as partial sums shift in.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_shift = {rem, quot[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
  end

  always_comb begin
    neg_res  = is_signed && (sign_a ^ sign_b);
    prod_fix = neg_res ? -acc : acc;
    quot_fix = neg_res ? -quot : quot;
    rem_fix  = (is_signed && sign_a) ? -rem : rem;
    if (!is_div) begin
      result = prod_fix;
    end else if (div_zero) begin
      result = {a_raw, {WIDTH{1'b1}}};
    end else begin
      result = {rem_fix, quot_fix};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      hilo_we   <= 1'b0;
      hilo_o    <= '0;
      is_signed <= 1'b0;
      is_div    <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
      a_raw     <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      acc       <= '0;
      rem       <= '0;
      quot      <= '0;
      cnt       <= '0;
    end else begin
      hilo_we <= 1'b0;
      if (flush) begin
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (is_arith) begin
                busy      <= 1'b1;
                is_signed <= is_signed_op;
                is_div    <= is_div_op;
                sign_a    <= is_signed_op && rs[WIDTH-1];
                sign_b    <= is_signed_op && rt[WIDTH-1];
                div_zero  <= (rt == '0);
                a_raw     <= rs;
                a_mag     <= rs_mag;
                b_mag     <= rt_mag;
                acc       <= {{WIDTH{1'b0}}, rt_mag};
                rem       <= '0;
                quot      <= rs_mag;
                cnt       <= CNT_W'(WIDTH);
              end else if (op == OP_MTHI) begin
                hilo_o  <= {rs, hilo_cur[WIDTH-1:0]};
                hilo_we <= 1'b1;
              end else if (op == OP_MTLO) begin
                hilo_o  <= {hilo_cur[2*WIDTH-1:WIDTH], rs};
                hilo_we <= 1'b1;
              end
            end
          end
          CALC: begin
            cnt <= cnt - CNT_W'(1);
            if (is_div) begin
              if (!div_diff[WIDTH+1]) begin
                rem  <= div_diff[WIDTH-1:0];
                quot <= {quot[WIDTH-2:0], 1'b1};
              end else begin
                rem  <= div_shift[WIDTH-1:0];
                quot <= {quot[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
          end
          FIX: begin
            hilo_o  <= result;
            hilo_we <= 1'b1;
            busy    <= 1'b0;
          end
          default: begin
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
